// File: rtl/reg_dest_pkg.sv
// Shared types and constants for the destination-register pipeline.
//   rdst_e       : reg_dst field encodings
//   stage_t      : per-stage pipeline entry {valid, we, dest}
//   DEST_W_MAX   : storage width of stage_t.dest; ADDR_W must not exceed it
//   LINK_REG_DEFAULT : default link register index
package reg_dest_pkg;

  localparam int unsigned DEST_W_MAX       = 8;
  localparam int unsigned LINK_REG_DEFAULT = 31;

  typedef enum logic [1:0] {
    RDST_RT   = 2'b00,
    RDST_RD   = 2'b01,
    RDST_LINK = 2'b10,
    RDST_NONE = 2'b11
  } rdst_e;

  // dest is stored at the widest legal width and zero-extended on entry
  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [DEST_W_MAX-1:0] dest;
  } stage_t;

endpackage

// File: rtl/reg_dest_pipe_if.sv
// Decode-side and write-back/hazard-side signals of reg_dest_pipe.
//   master : decode/hazard logic (drives instruction fields, stall/flush, queries)
//   slave  : reg_dest_pipe (returns write-back port and match/forward info)
interface reg_dest_pipe_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned STAGES = 3
);

  logic              in_valid;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic [1:0]        reg_dst;
  logic              reg_write;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] rs_q;
  logic [ADDR_W-1:0] rt_q;

  logic [ADDR_W-1:0] wb_dest;
  logic              wb_we;
  logic [STAGES-1:0] hit_rs;
  logic [STAGES-1:0] hit_rt;
  logic [2:0]        fwd_rs;
  logic [2:0]        fwd_rt;

  modport master (
    output in_valid, rt, rd, reg_dst, reg_write, stall, flush, rs_q, rt_q,
    input  wb_dest, wb_we, hit_rs, hit_rt, fwd_rs, fwd_rt
  );

  modport slave (
    input  in_valid, rt, rd, reg_dst, reg_write, stall, flush, rs_q, rt_q,
    output wb_dest, wb_we, hit_rs, hit_rt, fwd_rs, fwd_rt
  );

endinterface

// File: rtl/dest_sel.sv
// Combinational write-back destination select.
//   rt_i, rd_i   : instruction register fields
//   reg_dst_i    : rt / rd / link / none
//   reg_write_i  : instruction writes the register file
//   in_valid_i   : decode slot holds a real instruction
//   dest_o       : selected destination (0 for "none")
//   we_o         : effective write enable; never set for r0
module dest_sel
  import reg_dest_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LINK_REG = LINK_REG_DEFAULT
) (
  input  logic [ADDR_W-1:0] rt_i,
  input  logic [ADDR_W-1:0] rd_i,
  input  rdst_e             reg_dst_i,
  input  logic              reg_write_i,
  input  logic              in_valid_i,
  output logic [ADDR_W-1:0] dest_o,
  output logic              we_o
);

  // "none" maps to r0, so the r0 guard also suppresses its write
  always_comb begin
    dest_o = '0;
    we_o   = 1'b0;
    case (reg_dst_i)
      RDST_RT:   dest_o = rt_i;
      RDST_RD:   dest_o = rd_i;
      RDST_LINK: dest_o = ADDR_W'(LINK_REG);
      default:   dest_o = '0;
    endcase
    we_o = reg_write_i && in_valid_i && (reg_dst_i != RDST_NONE) && (dest_o != '0);
  end

endmodule

// File: rtl/reg_dest_pipe.sv
// Destination-register pipeline between decode and register-file write port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : reg_dest_pipe_if.slave
//     in_valid/rt/rd/reg_dst/reg_write : decode slot
//     stall/flush                      : pipeline control (flush wins)
//     rs_q/rt_q                        : hazard source queries
//     wb_dest/wb_we                    : oldest stage, drives write-back
//     hit_rs/hit_rt                    : per-stage producer match flags
//     fwd_rs/fwd_rt                    : youngest matching stage index
module reg_dest_pipe
  import reg_dest_pkg::*;
#(
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned STAGES       = 3,
  parameter int unsigned LINK_REG     = LINK_REG_DEFAULT,
  parameter int unsigned FLUSH_STAGES = 1
) (
  input logic            clk,
  input logic            rst_n,
  reg_dest_pipe_if.slave bus
);

  localparam int unsigned LAST = STAGES - 1;

  logic [ADDR_W-1:0] sel_dest;
  logic              sel_we;
  stage_t            entry_in;
  logic              flush_eff;

  stage_t stage_q [STAGES];
  stage_t stage_d [STAGES];

  logic [STAGES-1:0] hit_rs;
  logic [STAGES-1:0] hit_rt;
  logic [2:0]        fwd_rs;
  logic [2:0]        fwd_rt;

  dest_sel #(
    .ADDR_W   (ADDR_W),
    .LINK_REG (LINK_REG)
  ) u_dest_sel (
    .rt_i        (bus.rt),
    .rd_i        (bus.rd),
    .reg_dst_i   (rdst_e'(bus.reg_dst)),
    .reg_write_i (bus.reg_write),
    .in_valid_i  (bus.in_valid),
    .dest_o      (sel_dest),
    .we_o        (sel_we)
  );

  assign entry_in  = '{valid: bus.in_valid, we: sel_we, dest: DEST_W_MAX'(sel_dest)};
  // with FLUSH_STAGES=0 a flush request is simply ignored
  assign flush_eff = bus.flush && (FLUSH_STAGES != 0);

  // Next state: shift on a normal cycle or flush; flush invalidates the
  // FLUSH_STAGES youngest post-shift entries and overrides stall.
  always_comb begin
    for (int unsigned i = 0; i < STAGES; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (flush_eff || !bus.stall) begin
      stage_d[0] = flush_eff ? stage_t'('0) : entry_in;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage_d[i] = (flush_eff && (i < FLUSH_STAGES)) ? stage_t'('0) : stage_q[i-1];
      end
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  // Per-stage producer match; r0 is never a real dependency
  always_comb begin
    hit_rs = '0;
    hit_rt = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      hit_rs[i] = stage_q[i].valid && stage_q[i].we &&
                  (stage_q[i].dest == DEST_W_MAX'(bus.rs_q)) && (bus.rs_q != '0);
      hit_rt[i] = stage_q[i].valid && stage_q[i].we &&
                  (stage_q[i].dest == DEST_W_MAX'(bus.rt_q)) && (bus.rt_q != '0);
    end
  end

  // Youngest producer wins: scan oldest to youngest so the lowest index sticks
  always_comb begin
    fwd_rs = '0;
    fwd_rt = '0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      if (hit_rs[i]) fwd_rs = 3'(i);
      if (hit_rt[i]) fwd_rt = 3'(i);
    end
  end

  assign bus.wb_dest = ADDR_W'(stage_q[LAST].dest);
  assign bus.wb_we   = stage_q[LAST].valid && stage_q[LAST].we;
  assign bus.hit_rs  = hit_rs;
  assign bus.hit_rt  = hit_rt;
  assign bus.fwd_rs  = fwd_rs;
  assign bus.fwd_rt  = fwd_rt;

endmodule

// File: tb/tb_reg_dest_pipe.sv
// Self-checking bench for reg_dest_pipe (STAGES=3, FLUSH_STAGES=1, LINK_REG=31).
module tb_reg_dest_pipe;

  localparam int unsigned AW   = 5;
  localparam int unsigned ST   = 3;
  localparam int unsigned LINK = 31;
  localparam int unsigned FS   = 1;

  logic clk = 1'b0;
  logic rst_n;

  int errors = 0;
  int checks = 0;

  reg_dest_pipe_if #(.ADDR_W(AW), .STAGES(ST)) bus ();

  reg_dest_pipe #(
    .ADDR_W       (AW),
    .STAGES       (ST),
    .LINK_REG     (LINK),
    .FLUSH_STAGES (FS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: queue of in-flight instructions, index 0 = youngest
  typedef struct {
    bit v;
    bit we;
    int dest;
  } ent_t;

  ent_t mq[$];

  function automatic void model_reset();
    ent_t e;
    e = '{v: 1'b0, we: 1'b0, dest: 0};
    mq.delete();
    for (int k = 0; k < int'(ST); k++) mq.push_back(e);
  endfunction

  function automatic void model_edge();
    ent_t e;
    int   d;
    bit   w;
    case (bus.reg_dst)
      2'b00:   d = int'(bus.rt);
      2'b01:   d = int'(bus.rd);
      2'b10:   d = int'(LINK);
      default: d = 0;
    endcase
    w = bus.reg_write && bus.in_valid && (bus.reg_dst != 2'b11) && (d != 0);
    if (bus.flush) begin
      e = '{v: 1'b0, we: 1'b0, dest: 0};
      mq.push_front(e);
      void'(mq.pop_back());
      for (int k = 0; k < int'(FS); k++) mq[k].v = 1'b0;
    end else if (!bus.stall) begin
      e = '{v: bus.in_valid, we: w, dest: d};
      mq.push_front(e);
      void'(mq.pop_back());
    end
  endfunction

  // {wb_we, hit_rs, hit_rt, fwd_rs, fwd_rt} predicted from the queue
  function automatic logic [12:0] exp_vec();
    logic [ST-1:0] hr;
    logic [ST-1:0] ht;
    logic [2:0]    fr;
    logic [2:0]    ft;
    logic          wbwe;
    bit            fr_set;
    bit            ft_set;
    hr = '0; ht = '0; fr = '0; ft = '0; fr_set = 0; ft_set = 0;
    for (int k = 0; k < int'(ST); k++) begin
      hr[k] = mq[k].v && mq[k].we && (mq[k].dest == int'(bus.rs_q)) && (bus.rs_q != 0);
      ht[k] = mq[k].v && mq[k].we && (mq[k].dest == int'(bus.rt_q)) && (bus.rt_q != 0);
      if (hr[k] && !fr_set) begin fr = 3'(k); fr_set = 1; end
      if (ht[k] && !ft_set) begin ft = 3'(k); ft_set = 1; end
    end
    wbwe = mq[ST-1].v && mq[ST-1].we;
    return {wbwe, hr, ht, fr, ft};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {bus.wb_we, bus.hit_rs, bus.hit_rt, bus.fwd_rs, bus.fwd_rt};
  endfunction

  task automatic drive(input bit iv, input int rt, input int rd, input bit [1:0] rdst,
                       input bit rw, input bit st, input bit fl);
    bus.in_valid  = iv;
    bus.rt        = AW'(rt);
    bus.rd        = AW'(rd);
    bus.reg_dst   = rdst;
    bus.reg_write = rw;
    bus.stall     = st;
    bus.flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    bus.rs_q = '0;
    bus.rt_q = '0;
    model_reset();
    #12;
    checks++;
    if ({bus.wb_dest, obs_vec()} !== '0) begin
      errors++;
      $display("FAIL reset_hold got %h want 0", {bus.wb_dest, obs_vec()});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({bus.wb_dest, obs_vec()} !== '0) begin
      errors++;
      $display("FAIL reset_release got %h want 0", {bus.wb_dest, obs_vec()});
    end
    // fill with writes to r12, then reset asynchronously mid-cycle
    drive(1, 12, 0, 2'b00, 1, 0, 0);
    bus.rs_q = AW'(12);
    bus.rt_q = AW'(12);
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_fill got %h want %h", obs_vec(), exp_vec());
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.wb_we, bus.hit_rs, bus.hit_rt} !== 7'd0) begin
      errors++;
      $display("FAIL async_reset got %b want 0", {bus.wb_we, bus.hit_rs, bus.hit_rt});
    end
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.wb_we !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_wb edge %0d got %b want 0", k, bus.wb_we);
      end
    end
  endtask

  task automatic test_select_latency();
    int       ed [4] = '{8, 9, 31, 0};
    bit       ew [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bit [1:0] rdst;
    bus.rs_q = AW'(8);
    bus.rt_q = AW'(9);
    for (int k = 0; k < 7; k++) begin
      rdst = 2'(k);
      if (k < 4) drive(1, 8, 9, rdst, 1, 0, 0);
      else       drive(0, 0, 0, 2'b00, 0, 0, 0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL select_vec edge %0d got %h want %h", k, obs_vec(), exp_vec());
      end
      if (k >= 2 && k < 6) begin
        checks++;
        if ({bus.wb_dest, bus.wb_we} !== {AW'(ed[k-2]), ew[k-2]}) begin
          errors++;
          $display("FAIL select_wb edge %0d got %0d/%b want %0d/%b",
                   k, bus.wb_dest, bus.wb_we, ed[k-2], ew[k-2]);
        end
      end
    end
  endtask

  task automatic test_r0();
    bus.rs_q = '0;
    bus.rt_q = '0;
    drive(1, 5, 0, 2'b01, 1, 0, 0);
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if ({bus.wb_we, bus.hit_rs, bus.hit_rt} !== 7'd0) begin
      errors++;
      $display("FAIL r0_suppress got %b want 0", {bus.wb_we, bus.hit_rs, bus.hit_rt});
    end
  endtask

  task automatic test_stall();
    idle(3);
    bus.rs_q = AW'(5);
    bus.rt_q = AW'(6);
    drive(1, 5, 0, 2'b00, 1, 0, 0);
    tick();
    drive(1, 6, 0, 2'b00, 1, 1, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({bus.wb_we, bus.hit_rs, bus.hit_rt} !== {1'b0, 3'b001, 3'b000}) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got %b want 0001000", k,
                 {bus.wb_we, bus.hit_rs, bus.hit_rt});
      end
    end
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    tick();
    checks++;
    if ({bus.wb_we, bus.hit_rs} !== {1'b0, 3'b010}) begin
      errors++;
      $display("FAIL stall_resume got %b want 0010", {bus.wb_we, bus.hit_rs});
    end
    tick();
    checks++;
    if ({bus.wb_we, bus.wb_dest} !== {1'b1, AW'(5)}) begin
      errors++;
      $display("FAIL stall_wb got %b/%0d want 1/5", bus.wb_we, bus.wb_dest);
    end
  endtask

  task automatic test_flush_stall();
    idle(3);
    bus.rs_q = AW'(3);
    bus.rt_q = AW'(4);
    drive(1, 3, 0, 2'b00, 1, 0, 0);
    tick();
    drive(1, 4, 0, 2'b00, 1, 1, 1);
    tick();
    checks++;
    if ({bus.hit_rs, bus.hit_rt} !== {3'b010, 3'b000}) begin
      errors++;
      $display("FAIL flush_stall got %b want 010000", {bus.hit_rs, bus.hit_rt});
    end
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    tick();
    checks++;
    if ({bus.wb_we, bus.wb_dest, bus.hit_rt} !== {1'b1, AW'(3), 3'b000}) begin
      errors++;
      $display("FAIL flush_wb got %b/%0d/%b want 1/3/000", bus.wb_we, bus.wb_dest, bus.hit_rt);
    end
  endtask

  task automatic test_fwd_priority();
    idle(3);
    drive(1, 7, 0, 2'b00, 1, 0, 0);
    tick();
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    tick();
    drive(1, 7, 0, 2'b00, 1, 0, 0);
    tick();
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    bus.rs_q = AW'(7);
    bus.rt_q = AW'(7);
    #1;
    checks++;
    if ({bus.hit_rs, bus.hit_rt, bus.fwd_rs, bus.fwd_rt} !== {3'b101, 3'b101, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL fwd_two got %b/%b/%0d/%0d want 101/101/0/0",
               bus.hit_rs, bus.hit_rt, bus.fwd_rs, bus.fwd_rt);
    end
    tick();
    checks++;
    if ({bus.hit_rs, bus.fwd_rs} !== {3'b010, 3'd1}) begin
      errors++;
      $display("FAIL fwd_shift got %b/%0d want 010/1", bus.hit_rs, bus.fwd_rs);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) < 8), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) == 0));
      bus.rs_q = AW'($urandom_range(0, 7));
      bus.rt_q = AW'($urandom_range(0, 7));
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_vec iter %0d got %h want %h", n, obs_vec(), exp_vec());
      end
      if (mq[ST-1].v) begin
        checks++;
        if (bus.wb_dest !== AW'(mq[ST-1].dest)) begin
          errors++;
          $display("FAIL random_wb_dest iter %0d got %0d want %0d", n, bus.wb_dest, mq[ST-1].dest);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_select_latency();
    test_r0();
    test_stall();
    test_flush_stall();
    test_fwd_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_dest_pipe.md
Name: reg_dest_pipe

Overview:
Parametrised successor to the combinational destination-register selector. Selects the write-back destination (rt, rd, link register, or none), then carries destination, write-enable and valid through a STAGES-deep pipeline (EX/MEM/WB by default) with stall and flush. Exposes per-stage source-match flags and the youngest-match index so the hazard and forwarding unit can operate without duplicating destination tracking. Sits between decode and the register-file write port.

Parameters:
ADDR_W, 5, register-address width in bits
STAGES, 3, pipeline depth; stage 0 is youngest and stage STAGES-1 drives write-back; legal range 1..8
LINK_REG, 31, register index selected when reg_dst = 2'b10
FLUSH_STAGES, 1, number of youngest in-flight stages invalidated by flush; legal range 0..STAGES

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  decode slot holds a real instruction
rt  in  ADDR_W  rt field
rd  in  ADDR_W  rd field
reg_dst  in  2  destination select: 00 rt, 01 rd, 10 LINK_REG, 11 none
reg_write  in  1  instruction writes the register file
stall  in  1  hold the whole pipeline
flush  in  1  squash the youngest entries
rs_q  in  ADDR_W  source-query address A
rt_q  in  ADDR_W  source-query address B
wb_dest  out  ADDR_W  destination held in stage STAGES-1
wb_we  out  1  register-file write enable
hit_rs  out  STAGES  per-stage match flags for rs_q
hit_rt  out  STAGES  per-stage match flags for rt_q
fwd_rs  out  3  index of the youngest stage matching rs_q; 0 when hit_rs is 0
fwd_rt  out  3  index of the youngest stage matching rt_q; 0 when hit_rt is 0

Behaviour:
- Per-stage state is {valid, we, dest}.
- Reset (rst_n low, asynchronous): every stage clears to {0,0,0}. wb_dest, wb_we, hit_*, fwd_* are 0 while reset is asserted and in the first cycle after release.
- Destination select (combinational): reg_dst 00 selects rt, 01 selects rd, 10 selects LINK_REG, 11 selects dest 0 with we forced to 0. This replaces the legacy high-impedance output for code 11; no X or Z value is ever driven.
- Write-enable: we = reg_write AND in_valid AND (reg_dst != 11) AND (dest != 0). Writes to r0 never propagate.
- Normal cycle (stall=0, flush=0): stage i+1 takes stage i; stage 0 takes {in_valid, we, dest}.
- Latency: the value captured at edge N appears on wb_dest/wb_we after edge N+STAGES-1, i.e. STAGES edges from input to wb_we.
- Stall (stall=1, flush=0): all stages hold; the input is ignored; wb_we stays at its held value. The register file must be stalled in the same cycle.
- Flush (flush=1): has priority over stall. The entry entering stage 0 is invalid, and stages 0..FLUSH_STAGES-2 are cleared after the shift. Net effect: the FLUSH_STAGES youngest post-edge entries are invalid, and older stages shift normally. With FLUSH_STAGES=0, flush has no effect.
- wb_we = valid AND we of stage STAGES-1. wb_dest is the stored dest regardless of valid.
- hit_rs[i] = valid[i] AND we[i] AND (dest[i] == rs_q) AND (rs_q != 0). hit_rt is defined the same way with rt_q. Both are purely combinational from registered state and the query inputs.
- fwd_*: lowest-index set bit of hit_* (youngest producer wins). Zero-extended to 3 bits.

Decomposition:
- Shared package reg_dest_pkg holds:
  - reg_dst encodings RDST_RT=2'b00, RDST_RD=2'b01, RDST_LINK=2'b10, RDST_NONE=2'b11
  - stage-entry struct {valid, we, dest}
  - default LINK_REG constant
- One combinational sub-module, dest_sel: inputs rt, rd, reg_dst, reg_write, in_valid; outputs dest and we. It is instantiated once.
- Pipeline registers and hit/priority logic live in reg_dest_pipe.

Test Plan:
- Reset mid-stream: fill the pipe with we=1 entries, pull rst_n low asynchronously mid-cycle -> wb_we=0 and hit_*=0 immediately; after release, the next 3 edges still give wb_we=0.
- Select and latency: in_valid=1, reg_write=1, reg_dst 00/01/10/11 with rt=8, rd=9 on consecutive cycles -> wb_dest/wb_we = 8/1, 9/1, 31/1, 0/0, arriving 3 edges after each input.
- r0 suppression: rd=0, reg_dst=01, reg_write=1 -> wb_we=0; a query with rs_q=0 never sets hit_rs.
- Stall: issue dest 5, then assert stall for 2 cycles while the inputs change to dest 6 -> the pipe holds; dest 6 is not captured; dest 5 reaches WB 2 edges later than without the stall.
- Flush over stall: entries with dest 3 in stage 0 and dest 4 entering, flush=1 and stall=1 together -> dest 4 is dropped, dest 3 shifts to stage 1 with valid=1, and stage 0 becomes invalid (FLUSH_STAGES=1).
- Forwarding priority: dest 7 in stage 0 and stage 2, rs_q=7, rt_q=7 -> hit_rs=3'b101, fwd_rs=0, fwd_rt=0; after one edge with in_valid=0 -> hit_rs=3'b010, fwd_rs=1.
